// File: rtl/mod_mul_pkg.sv
// Shared defaults and FSM encoding for the sequential modular multiplier.
package mod_mul_pkg;

  localparam int unsigned SIZE_DEFAULT = 64;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RED_A = 3'd1,
    RED_B = 3'd2,
    STEP  = 3'd3,
    DONE  = 3'd4
  } state_e;

endpackage

// File: rtl/mod_mul_seq_mod_req_port.sv
// One dividend/divisor request and remainder response exchange with the external modulo unit.
module mod_req_port
  import mod_mul_pkg::*;
#(
  parameter int unsigned SIZE = SIZE_DEFAULT
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start_i,
  output logic            done_o,
  output logic [SIZE-1:0] result_o,
  output logic            dividen_tvalid_o,
  input  logic            dividen_tready_i,
  output logic            divisor_tvalid_o,
  input  logic            divisor_tready_i,
  input  logic [SIZE-1:0] result_tdata_i,
  input  logic            result_tvalid_i,
  output logic            result_tready_o
);

  logic dvd_pend_q, dvd_pend_d;
  logic dvs_pend_q, dvs_pend_d;
  logic wait_q, wait_d;

  // The response is only accepted once both request beats have left.
  assign result_tready_o  = wait_q & ~dvd_pend_q & ~dvs_pend_q;
  assign done_o           = result_tready_o & result_tvalid_i;
  assign result_o         = result_tdata_i;
  assign dividen_tvalid_o = dvd_pend_q & ~rst;
  assign divisor_tvalid_o = dvs_pend_q & ~rst;

  // NOTE: every always_comb output gets its default first, so no path can infer a latch.
  always_comb begin
    dvd_pend_d = dvd_pend_q;
    dvs_pend_d = dvs_pend_q;
    wait_d     = wait_q;
    if (dvd_pend_q && dividen_tready_i) dvd_pend_d = 1'b0;
    if (dvs_pend_q && divisor_tready_i) dvs_pend_d = 1'b0;
    if (done_o)                         wait_d     = 1'b0;
    if (start_i) begin
      dvd_pend_d = 1'b1;
      dvs_pend_d = 1'b1;
      wait_d     = 1'b1;
    end
  end

  // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      dvd_pend_q <= 1'b0;
      dvs_pend_q <= 1'b0;
      wait_q     <= 1'b0;
    end else begin
      dvd_pend_q <= dvd_pend_d;
      dvs_pend_q <= dvs_pend_d;
      wait_q     <= wait_d;
    end
  end

endmodule

// File: rtl/mod_mul_seq.sv
// Computes a*b mod n by reducing a and b, then MSB-first double-and-add with a remainder per bit.
module mod_mul_seq
  import mod_mul_pkg::*;
#(
  parameter int unsigned SIZE = SIZE_DEFAULT
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [SIZE-1:0] input_a_tdata,
  input  logic            input_a_tvalid,
  output logic            input_a_tready,
  input  logic [SIZE-1:0] input_b_tdata,
  input  logic            input_b_tvalid,
  output logic            input_b_tready,
  input  logic [SIZE-1:0] input_modulus_tdata,
  input  logic            input_modulus_tvalid,
  output logic            input_modulus_tready,
  output logic [SIZE-1:0] mod_dividen_tdata,
  output logic            mod_dividen_tvalid,
  input  logic            mod_dividen_tready,
  output logic [SIZE-1:0] mod_divisor_tdata,
  output logic            mod_divisor_tvalid,
  input  logic            mod_divisor_tready,
  input  logic [SIZE-1:0] mod_result_tdata,
  input  logic            mod_result_tvalid,
  output logic            mod_result_tready,
  output logic [SIZE-1:0] output_tdata,
  output logic            output_tvalid,
  input  logic            output_tready,
  output logic            busy
);

  localparam int unsigned IW = $clog2(SIZE);

  state_e          state_q, state_d;
  logic [SIZE-1:0] r_q, r_d;
  logic [SIZE-1:0] ar_q, ar_d;
  logic [SIZE-1:0] br_q, br_d;
  logic [SIZE-1:0] n_q, n_d;
  logic [IW-1:0]   i_q, i_d;

  logic            all_valid;
  logic            start;
  logic            done;
  logic            port_rdy;
  logic [SIZE-1:0] mod_res;
  logic [SIZE-1:0] t_lo;

  assign all_valid = input_a_tvalid & input_b_tvalid & input_modulus_tvalid;

  // Low SIZE bits of t = 2r + (ar[i] ? br : 0); the upper bits are zero whenever n is in range.
  assign t_lo = {r_q[SIZE-2:0], 1'b0} + (ar_q[i_q] ? br_q : '0);

  assign mod_divisor_tdata = n_q;
  assign output_tdata      = r_q;
  assign busy              = (state_q != IDLE) & ~rst;
  // IDLE keeps the response channel open so a reply stranded by reset is drained.
  assign mod_result_tready = port_rdy | (state_q == IDLE);

  mod_req_port #(.SIZE(SIZE)) u_req (
    .clk              (clk),
    .rst              (rst),
    .start_i          (start),
    .done_o           (done),
    .result_o         (mod_res),
    .dividen_tvalid_o (mod_dividen_tvalid),
    .dividen_tready_i (mod_dividen_tready),
    .divisor_tvalid_o (mod_divisor_tvalid),
    .divisor_tready_i (mod_divisor_tready),
    .result_tdata_i   (mod_result_tdata),
    .result_tvalid_i  (mod_result_tvalid),
    .result_tready_o  (port_rdy)
  );

  always_comb begin
    state_d              = state_q;
    r_d                  = r_q;
    ar_d                 = ar_q;
    br_d                 = br_q;
    n_d                  = n_q;
    i_d                  = i_q;
    start                = 1'b0;
    input_a_tready       = 1'b0;
    input_b_tready       = 1'b0;
    input_modulus_tready = 1'b0;
    output_tvalid        = 1'b0;
    mod_dividen_tdata    = '0;

    unique case (state_q)
      IDLE: begin
        if (all_valid && !rst) begin
          input_a_tready       = 1'b1;
          input_b_tready       = 1'b1;
          input_modulus_tready = 1'b1;
          ar_d                 = input_a_tdata;
          br_d                 = input_b_tdata;
          n_d                  = input_modulus_tdata;
          r_d                  = '0;
          i_d                  = IW'(SIZE - 1);
          if (input_modulus_tdata == '0) begin
            state_d = DONE;
          end else begin
            state_d = RED_A;
            start   = 1'b1;
          end
        end
      end
      RED_A: begin
        mod_dividen_tdata = ar_q;
        if (done) begin
          ar_d    = mod_res;
          state_d = RED_B;
          start   = 1'b1;
        end
      end
      RED_B: begin
        mod_dividen_tdata = br_q;
        if (done) begin
          br_d    = mod_res;
          state_d = STEP;
          start   = 1'b1;
        end
      end
      STEP: begin
        mod_dividen_tdata = t_lo;
        if (done) begin
          r_d = mod_res;
          if (i_q == '0) begin
            state_d = DONE;
          end else begin
            i_d   = i_q - 1'b1;
            start = 1'b1;
          end
        end
      end
      DONE: begin
        output_tvalid = ~rst;
        if (output_tready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      r_q     <= '0;
      ar_q    <= '0;
      br_q    <= '0;
      n_q     <= '0;
      i_q     <= '0;
    end else begin
      state_q <= state_d;
      r_q     <= r_d;
      ar_q    <= ar_d;
      br_q    <= br_d;
      n_q     <= n_d;
      i_q     <= i_d;
    end
  end

endmodule

// File: tb/tb_mod_mul_seq.sv
// Directed bench for mod_mul_seq with a behavioural modulo unit that can stall every channel.
module tb_mod_mul_seq;

  localparam int SIZE = 64;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [SIZE-1:0] input_a_tdata = '0;
  logic            input_a_tvalid = 1'b0;
  logic            input_a_tready;
  logic [SIZE-1:0] input_b_tdata = '0;
  logic            input_b_tvalid = 1'b0;
  logic            input_b_tready;
  logic [SIZE-1:0] input_modulus_tdata = '0;
  logic            input_modulus_tvalid = 1'b0;
  logic            input_modulus_tready;
  logic [SIZE-1:0] mod_dividen_tdata;
  logic            mod_dividen_tvalid;
  logic            mod_dividen_tready = 1'b1;
  logic [SIZE-1:0] mod_divisor_tdata;
  logic            mod_divisor_tvalid;
  logic            mod_divisor_tready = 1'b1;
  logic [SIZE-1:0] mod_result_tdata = '0;
  logic            mod_result_tvalid = 1'b0;
  logic            mod_result_tready;
  logic [SIZE-1:0] output_tdata;
  logic            output_tvalid;
  logic            output_tready = 1'b0;
  logic            busy;

  int checks   = 0;
  int failures = 0;

  bit              stall_en  = 1'b0;
  bit              res_block = 1'b0;
  logic [SIZE-1:0] cur_n     = '0;

  // Modulo stub state and monitors
  bit              dvd_have = 1'b0, dvs_have = 1'b0, res_wait = 1'b0;
  logic [SIZE-1:0] dvd_val = '0, dvs_val = '0, res_data = '0;
  int              dvd_dly = 0, dvs_dly = 0, res_dly = 0;
  int              exch_cnt = 0, dvd_seen = 0, stab_err = 0, dvs_err = 0;
  bit              out_hold = 1'b0, dvd_hold = 1'b0, dvs_hold = 1'b0;
  logic [SIZE-1:0] out_hold_d = '0, dvd_hold_d = '0, dvs_hold_d = '0;

  logic            dvd_hs, dvs_hs, res_hs, dvd_now, dvs_now;
  logic [SIZE-1:0] dvd_now_val, dvs_now_val;

  always #5 clk = ~clk;

  mod_mul_seq #(.SIZE(SIZE)) dut (
    .clk                  (clk),
    .rst                  (rst),
    .input_a_tdata        (input_a_tdata),
    .input_a_tvalid       (input_a_tvalid),
    .input_a_tready       (input_a_tready),
    .input_b_tdata        (input_b_tdata),
    .input_b_tvalid       (input_b_tvalid),
    .input_b_tready       (input_b_tready),
    .input_modulus_tdata  (input_modulus_tdata),
    .input_modulus_tvalid (input_modulus_tvalid),
    .input_modulus_tready (input_modulus_tready),
    .mod_dividen_tdata    (mod_dividen_tdata),
    .mod_dividen_tvalid   (mod_dividen_tvalid),
    .mod_dividen_tready   (mod_dividen_tready),
    .mod_divisor_tdata    (mod_divisor_tdata),
    .mod_divisor_tvalid   (mod_divisor_tvalid),
    .mod_divisor_tready   (mod_divisor_tready),
    .mod_result_tdata     (mod_result_tdata),
    .mod_result_tvalid    (mod_result_tvalid),
    .mod_result_tready    (mod_result_tready),
    .output_tdata         (output_tdata),
    .output_tvalid        (output_tvalid),
    .output_tready        (output_tready),
    .busy                 (busy)
  );

  assign dvd_hs      = mod_dividen_tvalid && mod_dividen_tready;
  assign dvs_hs      = mod_divisor_tvalid && mod_divisor_tready;
  assign res_hs      = mod_result_tvalid && mod_result_tready;
  assign dvd_now     = dvd_have || dvd_hs;
  assign dvs_now     = dvs_have || dvs_hs;
  assign dvd_now_val = dvd_hs ? mod_dividen_tdata : dvd_val;
  assign dvs_now_val = dvs_hs ? mod_divisor_tdata : dvs_val;

  function automatic int rnd_dly();
    return stall_en ? int'($urandom_range(5, 0)) : 0;
  endfunction

  always @(posedge clk) begin
    if (dvd_hs) exch_cnt <= exch_cnt + 1;
    if (mod_dividen_tvalid) dvd_seen <= dvd_seen + 1;

    if (dvd_hs) begin
      mod_dividen_tready <= 1'b0;
      dvd_dly            <= rnd_dly();
    end else if (!mod_dividen_tready) begin
      if (dvd_dly == 0) mod_dividen_tready <= 1'b1;
      else              dvd_dly            <= dvd_dly - 1;
    end

    if (dvs_hs) begin
      mod_divisor_tready <= 1'b0;
      dvs_dly            <= rnd_dly();
    end else if (!mod_divisor_tready) begin
      if (dvs_dly == 0) mod_divisor_tready <= 1'b1;
      else              dvs_dly            <= dvs_dly - 1;
    end

    if (res_hs) mod_result_tvalid <= 1'b0;
    if (dvd_now && dvs_now) begin
      dvd_have <= 1'b0;
      dvs_have <= 1'b0;
      res_data <= (dvs_now_val == '0) ? '0 : dvd_now_val % dvs_now_val;
      res_dly  <= rnd_dly();
      res_wait <= 1'b1;
    end else begin
      dvd_have <= dvd_now;
      dvs_have <= dvs_now;
      if (dvd_hs) dvd_val <= mod_dividen_tdata;
      if (dvs_hs) dvs_val <= mod_divisor_tdata;
      if (res_wait && !res_block) begin
        if (res_dly == 0) begin
          mod_result_tvalid <= 1'b1;
          mod_result_tdata  <= res_data;
          res_wait          <= 1'b0;
        end else begin
          res_dly <= res_dly - 1;
        end
      end
    end
  end

  // Stability of stalled payloads and of the divisor value.
  always @(posedge clk) begin
    if (!rst && out_hold && (!output_tvalid || output_tdata !== out_hold_d)) stab_err <= stab_err + 1;
    else if (!rst && dvd_hold && (!mod_dividen_tvalid || mod_dividen_tdata !== dvd_hold_d)) stab_err <= stab_err + 1;
    else if (!rst && dvs_hold && (!mod_divisor_tvalid || mod_divisor_tdata !== dvs_hold_d)) stab_err <= stab_err + 1;
    out_hold   <= !rst && output_tvalid && !output_tready;
    out_hold_d <= output_tdata;
    dvd_hold   <= !rst && mod_dividen_tvalid && !mod_dividen_tready;
    dvd_hold_d <= mod_dividen_tdata;
    dvs_hold   <= !rst && mod_divisor_tvalid && !mod_divisor_tready;
    dvs_hold_d <= mod_divisor_tdata;
    if (!rst && mod_divisor_tvalid && mod_divisor_tdata !== cur_n) dvs_err <= dvs_err + 1;
  end

  task automatic set_inputs(input logic [SIZE-1:0] a, b, n, input bit v);
    input_a_tdata        = a;
    input_b_tdata        = b;
    input_modulus_tdata  = n;
    input_a_tvalid       = v;
    input_b_tvalid       = v;
    input_modulus_tvalid = v;
  endtask

  // Runs one operation from a negedge; returns at the negedge after the output handshake.
  task automatic run_op(input logic [SIZE-1:0] a, b, n, input bit out_stall,
                        output logic [SIZE-1:0] res, output int exch, output bit ok);
    int base;
    int waited;
    ok    = 1'b1;
    res   = '0;
    exch  = 0;
    cur_n = n;
    set_inputs(a, b, n, 1'b1);
    output_tready = !out_stall;
    #1;
    waited = 0;
    while (!input_a_tready && waited < 50) begin
      @(negedge clk);
      #1;
      waited++;
    end
    if (!input_a_tready) begin
      ok = 1'b0;
      set_inputs(a, b, n, 1'b0);
      return;
    end
    base = exch_cnt;
    @(negedge clk);
    set_inputs(a, b, n, 1'b0);
    waited = 0;
    while (!output_tvalid && waited < 5000) begin
      @(negedge clk);
      waited++;
    end
    if (!output_tvalid) begin
      ok = 1'b0;
      return;
    end
    res = output_tdata;
    if (out_stall) begin
      repeat (10) @(negedge clk);
      output_tready = 1'b1;
    end
    @(negedge clk);
    if (out_stall) output_tready = 1'b0;
    exch = exch_cnt - base;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    set_inputs(64'd1, 64'd2, 64'd3, 1'b1);
    output_tready = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rst_busy: got %b want 0", busy); end
    checks++; if ({input_a_tready, input_b_tready, input_modulus_tready} !== 3'b000) begin
      failures++; $display("FAIL rst_in_ready: got %b want 000", {input_a_tready, input_b_tready, input_modulus_tready}); end
    checks++; if ({output_tvalid, mod_dividen_tvalid, mod_divisor_tvalid} !== 3'b000) begin
      failures++; $display("FAIL rst_tvalids: got %b want 000", {output_tvalid, mod_dividen_tvalid, mod_divisor_tvalid}); end
    checks++; if (output_tdata !== '0) begin failures++; $display("FAIL rst_out_data: got %0d want 0", output_tdata); end
    set_inputs('0, '0, '0, 1'b0);
    rst = 1'b0;
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL idle_busy: got %b want 0", busy); end
    checks++; if (mod_result_tready !== 1'b1) begin failures++; $display("FAIL idle_res_ready: got %b want 1", mod_result_tready); end
  endtask

  task automatic test_basic();
    logic [SIZE-1:0] res;
    int exch;
    bit ok;
    int dvs_base;
    dvs_base = dvs_err;
    run_op(64'd7, 64'd9, 64'd5, 1'b0, res, exch, ok);
    checks++; if (ok !== 1'b1) begin failures++; $display("FAIL basic_done: timeout got ok=%b want 1", ok); end
    checks++; if (res !== 64'd3) begin failures++; $display("FAIL basic_result: got %0d want 3", res); end
    checks++; if (exch !== 66) begin failures++; $display("FAIL basic_exchanges: got %0d want 66", exch); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL basic_busy_after: got %b want 0", busy); end
    checks++; if (dvs_err - dvs_base !== 0) begin failures++; $display("FAIL basic_divisor: got %0d bad beats want 0", dvs_err - dvs_base); end
  endtask

  task automatic test_zero();
    logic [SIZE-1:0] res;
    int exch;
    bit ok;
    int seen_base;
    run_op(64'd0, 64'd12345, 64'd97, 1'b0, res, exch, ok);
    checks++; if (!ok || res !== 64'd0) begin failures++; $display("FAIL zero_a: got %0d ok=%b want 0", res, ok); end
    checks++; if (exch !== 66) begin failures++; $display("FAIL zero_a_exch: got %0d want 66", exch); end
    seen_base = dvd_seen;
    run_op(64'd3, 64'd4, 64'd0, 1'b0, res, exch, ok);
    checks++; if (!ok || res !== 64'd0) begin failures++; $display("FAIL zero_n: got %0d ok=%b want 0", res, ok); end
    checks++; if (dvd_seen - seen_base !== 0) begin
      failures++; $display("FAIL zero_n_no_req: got %0d dividend-valid cycles want 0", dvd_seen - seen_base); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL zero_n_busy: got %b want 0", busy); end
  endtask

  task automatic test_values();
    logic [SIZE-1:0] res;
    int exch;
    bit ok;
    run_op(64'h1FFF_FFFF_FFFF_FFFE, 64'h1FFF_FFFF_FFFF_FFFE, 64'h1FFF_FFFF_FFFF_FFFF, 1'b0, res, exch, ok);
    checks++; if (!ok || res !== 64'd1) begin failures++; $display("FAIL big_result: got %0d ok=%b want 1", res, ok); end
    run_op(64'd100, 64'd200, 64'd37, 1'b0, res, exch, ok);
    checks++; if (!ok || res !== 64'd20) begin failures++; $display("FAIL mid_result: got %0d ok=%b want 20", res, ok); end
    run_op(64'd13, 64'd11, 64'd1, 1'b0, res, exch, ok);
    checks++; if (!ok || res !== 64'd0) begin failures++; $display("FAIL n1_result: got %0d ok=%b want 0", res, ok); end
  endtask

  task automatic test_stall();
    logic [SIZE-1:0] res;
    int exch;
    bit ok;
    int stab_base;
    stab_base = stab_err;
    stall_en  = 1'b1;
    run_op(64'd7, 64'd9, 64'd5, 1'b1, res, exch, ok);
    checks++; if (!ok || res !== 64'd3) begin failures++; $display("FAIL stall_result_a: got %0d ok=%b want 3", res, ok); end
    checks++; if (exch !== 66) begin failures++; $display("FAIL stall_exch: got %0d want 66", exch); end
    run_op(64'd100, 64'd200, 64'd37, 1'b1, res, exch, ok);
    checks++; if (!ok || res !== 64'd20) begin failures++; $display("FAIL stall_result_b: got %0d ok=%b want 20", res, ok); end
    stall_en = 1'b0;
    checks++; if (stab_err - stab_base !== 0) begin
      failures++; $display("FAIL stall_stability: got %0d unstable beats want 0", stab_err - stab_base); end
  endtask

  task automatic test_reset_mid();
    logic [SIZE-1:0] res;
    int exch;
    bit ok;
    int base;
    int waited;
    bit bad_out;
    cur_n = 64'd5;
    set_inputs(64'd7, 64'd9, 64'd5, 1'b1);
    output_tready = 1'b1;
    #1;
    waited = 0;
    while (!input_a_tready && waited < 50) begin @(negedge clk); #1; waited++; end
    base = exch_cnt;
    @(negedge clk);
    set_inputs('0, '0, '0, 1'b0);
    waited = 0;
    while ((exch_cnt - base) < 5 && waited < 500) begin @(negedge clk); waited++; end
    res_block = 1'b1;
    waited = 0;
    while (!res_wait && waited < 100) begin @(negedge clk); waited++; end
    checks++; if (res_wait !== 1'b1 || busy !== 1'b1) begin
      failures++; $display("FAIL mid_pending: got pending=%b busy=%b want 1 1", res_wait, busy); end
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst       = 1'b0;
    res_block = 1'b0;
    bad_out   = 1'b0;
    waited    = 0;
    while ((res_wait || mod_result_tvalid) && waited < 50) begin
      @(negedge clk);
      if (output_tvalid || busy) bad_out = 1'b1;
      waited++;
    end
    checks++; if (res_wait || mod_result_tvalid) begin
      failures++; $display("FAIL mid_drain: got pending=%b valid=%b want 0 0", res_wait, mod_result_tvalid); end
    checks++; if (bad_out !== 1'b0) begin failures++; $display("FAIL mid_no_output: got %b want 0", bad_out); end
    run_op(64'd10, 64'd10, 64'd7, 1'b0, res, exch, ok);
    checks++; if (!ok || res !== 64'd2) begin failures++; $display("FAIL mid_next_result: got %0d ok=%b want 2", res, ok); end
    checks++; if (exch !== 66) begin failures++; $display("FAIL mid_next_exch: got %0d want 66", exch); end
  endtask

  task automatic test_partial();
    logic [SIZE-1:0] res;
    int exch;
    bit ok;
    input_a_tdata  = 64'd20;
    input_a_tvalid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      checks++; if ({input_a_tready, input_b_tready, input_modulus_tready, busy} !== 4'b0000) begin
        failures++; $display("FAIL partial_a_only: got %b want 0000", {input_a_tready, input_b_tready, input_modulus_tready, busy}); end
    end
    input_b_tdata  = 64'd30;
    input_b_tvalid = 1'b1;
    @(negedge clk);
    checks++; if ({input_a_tready, input_b_tready, input_modulus_tready, busy} !== 4'b0000) begin
      failures++; $display("FAIL partial_ab: got %b want 0000", {input_a_tready, input_b_tready, input_modulus_tready, busy}); end
    run_op(64'd20, 64'd30, 64'd11, 1'b0, res, exch, ok);
    checks++; if (!ok || res !== 64'd6) begin failures++; $display("FAIL partial_result: got %0d ok=%b want 6", res, ok); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_zero();
    test_values();
    test_stall();
    test_reset_mid();
    test_partial();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mod_mul_seq.md
MOD_MUL_SEQ -- requirements
Module: mod_mul_seq

Interface
REQ-001 The block SHALL have parameter SIZE, default 64, giving the operand, modulus and result width in bits.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all logic is rising-edge.
REQ-003 The block SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-004 The block SHALL have ports input_a_tdata (in, SIZE), input_a_tvalid (in, 1) and input_a_tready (out, 1): multiplicand stream.
REQ-005 The block SHALL have ports input_b_tdata (in, SIZE), input_b_tvalid (in, 1) and input_b_tready (out, 1): multiplier stream.
REQ-006 The block SHALL have ports input_modulus_tdata (in, SIZE), input_modulus_tvalid (in, 1) and input_modulus_tready (out, 1): modulus n.
REQ-007 The block SHALL have ports mod_dividen_tdata (out, SIZE), mod_dividen_tvalid (out, 1) and mod_dividen_tready (in, 1): dividend request to the external modulo_eq.
REQ-008 The block SHALL have ports mod_divisor_tdata (out, SIZE), mod_divisor_tvalid (out, 1) and mod_divisor_tready (in, 1): divisor request to modulo_eq.
REQ-009 The block SHALL have ports mod_result_tdata (in, SIZE), mod_result_tvalid (in, 1) and mod_result_tready (out, 1): remainder returned by modulo_eq.
REQ-010 The block SHALL have ports output_tdata (out, SIZE), output_tvalid (out, 1) and output_tready (in, 1): result a*b mod n.
REQ-011 The block SHALL have port busy, output, 1 bit: high whenever the state is not IDLE.

Function
REQ-012 Every transfer SHALL occur on a clock edge where tvalid and tready are both high; sources hold tdata stable until that edge.
REQ-013 In IDLE, all three input treadys SHALL be high only when all three input tvalids are high, so a, b and n are captured together in one cycle.
REQ-014 The states SHALL be IDLE, RED_A, RED_B, STEP, DONE; RED_A, RED_B and STEP each use one modulo request/response exchange.
REQ-015 Exchange: mod_dividen_tvalid and mod_divisor_tvalid SHALL rise together; each SHALL drop independently after its own handshake; mod_result_tready SHALL rise after both are sent; the result is captured on the mod_result handshake.
REQ-016 mod_divisor_tdata SHALL always equal the captured n.
REQ-017 RED_A SHALL request a mod n into register ar; RED_B SHALL request b mod n into register br; r SHALL be set to 0 and bit index i to SIZE-1.
REQ-018 STEP SHALL form t = 2r + (ar[i] ? br : 0) in SIZE+2 bits, send t[SIZE-1:0] as the dividend, and set r to the result; i decrements; after i=0 the state moves to DONE.
REQ-019 Exactly SIZE+2 modulo exchanges SHALL occur per operation when n != 0.
REQ-020 Valid range SHALL be 1 <= n < 2^(SIZE-2), which guarantees t < 2^SIZE; outside this range the result is unspecified, but the handshakes SHALL still complete.
REQ-021 If n == 0, the block SHALL go from IDLE directly to DONE with output_tdata = 0 and issue no modulo requests.
REQ-022 In DONE, output_tvalid SHALL be high with stable output_tdata = r until output_tready; on that handshake the state returns to IDLE.
REQ-023 Input treadys SHALL be low outside IDLE, so back-to-back operations are accepted no earlier than the cycle after the output handshake.
REQ-024 In IDLE, mod_result_tready SHALL be high and any returned result SHALL be discarded, draining a response stranded by reset.
REQ-025 Minimum latency SHALL be 2 cycles per exchange plus 2 cycles (capture, DONE); stalls on any tready or tvalid only extend latency.

Reset
REQ-026 With rst high at a clock edge, the block SHALL enter IDLE with r, ar, br, i and output_tdata cleared.
REQ-027 During reset, all tvalid outputs, input treadys and busy SHALL be 0.
REQ-028 Reset mid-operation SHALL abandon the operation without emitting an output.

Structure
REQ-029 Package mod_mul_pkg SHALL hold the SIZE default and the state encoding enum.
REQ-030 One sub-module, mod_req_port, SHALL implement the single-exchange handshake of REQ-015 with a start pulse, a done pulse and the result, and SHALL be used by all three request states.

Verification
REQ-031 a=7, b=9, n=5 -> output 3 after exactly 66 modulo exchanges; busy falls after the output handshake.
REQ-032 a=0, b=12345, n=97 -> output 0; a=3, b=4, n=0 -> output 0 with no mod_dividen_tvalid ever asserted.
REQ-033 a=b=2^61-2, n=2^61-1 -> output 1.
REQ-034 Modulo stub inserts random 0-5 cycle delays on each tready and on tvalid, and output_tready is low for 10 cycles -> same results, tdata stable while stalled.
REQ-035 rst pulsed during STEP with a response pending -> IDLE, stale result drained and discarded, next operation a=10, b=10, n=7 -> output 2.
REQ-036 Only input_a_tvalid is asserted -> no tready is raised and no capture occurs until all three tvalids are high.
